imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Sequencer that owns the single byte-wide port of the instruction memory. After reset it runs a program-load phase that streams bytes into memory. It then runs a fetch phase: it reads four consecutive bytes per instruction, assembles them big-endian (byte at PC is bits 31:24), and presents the word to decode with a valid/stall handshake. It holds the architectural PC and accepts branch redirects.

Parameters:
ADDR_W, 9, memory byte-address width (2^ADDR_W bytes; must be >= 2)
RESET_PC, 32'h0000_0000, PC value after reset and after load completion

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
load_valid  in  1  load byte offered
load_data  in  8  load byte
load_done  in  1  end of program load (level sampled in LOAD only)
load_ready  out  1  controller accepts load bytes (registered)
mem_addr  out  ADDR_W  memory byte address
mem_we  out  1  memory byte write enable
mem_wdata  out  8  memory write byte
mem_rdata  in  8  memory read byte; synchronous read, returned the cycle after mem_addr
stall  in  1  decode cannot accept instr this cycle
redirect_valid  in  1  branch/jump redirect
redirect_pc  in  32  redirect target
instr_valid  out  1  instr/instr_pc valid
instr  out  32  assembled instruction
instr_pc  out  32  byte address of instr
pc  out  32  current fetch PC
misalign  out  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- Reset (any state, mid-operation included):
  - state=LOAD, load pointer=0, pc=RESET_PC.
  - load_ready=0, instr_valid=0, instr=0, instr_pc=0, misalign=0, mem_we=0.
  - load_ready becomes 1 in the first cycle after rst deasserts.
- States: LOAD, FETCH (beat counter k=0..4), HOLD.
- LOAD:
  - mem_addr=load pointer; mem_wdata=load_data; mem_we=load_valid&load_ready (combinational).
  - On each accepted byte, pointer increments.
  - If the accepted byte went to address 2^ADDR_W-1, or load_done=1 in the same cycle, the byte is written and the next state is FETCH k=0. load_ready goes to 0 next cycle.
  - load_done with no byte: go to FETCH k=0.
  - pc=RESET_PC on exit. redirect_valid and stall are ignored in LOAD.
- FETCH:
  - Cycles k=0..3 drive mem_addr=pc[ADDR_W-1:0]+k, with mem_we=0.
  - Cycles k=1..4 capture mem_rdata into byte lanes 3..0 (big-endian).
  - End of k=4: instr/instr_pc registered, instr_valid=1, state=HOLD.
  - First instr_valid appears 5 cycles after the k=0 cycle.
- HOLD: instr/instr_pc/instr_valid held stable while stall=1. If stall=0, the word is accepted: pc<=pc+4 (32-bit wrap, FFFF_FFFC->0), instr_valid<=0, next state FETCH k=0.
- Unstalled throughput: one instruction per 6 cycles.
- Redirect (FETCH or HOLD): highest priority, over stall and over acceptance.
  - pc<={redirect_pc[31:2],2'b00}; instr_valid<=0; partial bytes discarded; next state FETCH k=0.
  - misalign pulses if redirect_pc[1:0]!=0.
- Address wrap: pc above memory size is truncated to ADDR_W bits. Because pc is always aligned, a word never straddles the wrap.
- mem_we is never 1 outside LOAD.

Test Plan:
1. Load program, first word: reset, then load bytes 00 43 08 20 00 43 08 22 00 62 08 20 followed by load_done, with stall=0 -> instr 0x00430820 with instr_pc 0, instr_valid high 5 cycles after the k=0 cycle.
2. Load program, remaining words: continue scenario 1 -> instr 0x00430822 with instr_pc 4 (6 cycles later), then 0x00620820 with instr_pc 8; mem_we seen exactly 12 times.
3. Stall: hold stall=1 for 3 cycles while instr_valid=1 (instr_pc 0) -> instr 0x00430820 stable, pc stays 0; pc=4 the cycle after stall drops.
4. Redirect: redirect_valid with redirect_pc=0x8 at FETCH k=2 -> no word issued for pc 0; next instr 0x00620820 with instr_pc 8; misalign=0. Redirect with redirect_pc=0x6 -> pc=4, misalign one-cycle pulse, instr 0x00430822.
5. Full load: stream 2^ADDR_W bytes without load_done -> auto-transition to FETCH after the byte at the last address; load_ready=0 next cycle. Next: load_done=1 with load_valid=1 in the same cycle -> that byte is written before FETCH.
6. Reset mid-fetch: rst at FETCH k=3 -> next cycle instr_valid=0, pc=RESET_PC, mem_we=0, load_ready=0; load_ready=1 after rst deasserts; memory contents reloadable.

Source files
------------

// File: rtl/imem_fetch_if.sv
// Bundle of load, memory-port and decode-side signals for the instruction-memory
// fetch controller; master is the controller, slave is its environment.
interface imem_fetch_if #(
    parameter int ADDR_W = 9
);
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_done;
    logic              load_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic [31:0]       pc;
    logic              misalign;

    modport master (
        input  load_valid, load_data, load_done, mem_rdata,
               stall, redirect_valid, redirect_pc,
        output load_ready, mem_addr, mem_we, mem_wdata,
               instr_valid, instr, instr_pc, pc, misalign
    );

    modport slave (
        output load_valid, load_data, load_done, mem_rdata,
               stall, redirect_valid, redirect_pc,
        input  load_ready, mem_addr, mem_we, mem_wdata,
               instr_valid, instr, instr_pc, pc, misalign
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Owns the byte-wide instruction memory port: streams a program in after reset,
// then fetches four bytes per instruction and hands big-endian words to decode.
module imem_fetch_ctrl #(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    imem_fetch_if.master bus
);
    localparam logic [1:0]        ST_LOAD   = 2'd0;
    localparam logic [1:0]        ST_FETCH  = 2'd1;
    localparam logic [1:0]        ST_HOLD   = 2'd2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [1:0]        r_state;
    logic [2:0]        r_k;
    logic [ADDR_W-1:0] r_ptr;
    logic [31:0]       r_pc;
    logic              r_load_ready;
    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic [31:0]       r_instr_pc;
    logic              r_misalign;
    logic [23:0]       r_lanes;

    logic              w_in_load;
    logic              w_accept;
    logic              w_load_exit;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_fetch_addr;

    // No byte is written while reset is held, even if load_ready is still high.
    assign w_in_load    = (r_state == ST_LOAD);
    assign w_accept     = w_in_load & r_load_ready & bus.load_valid & ~rst;
    assign w_load_exit  = bus.load_done | (w_accept & (r_ptr == LAST_ADDR));
    assign w_redirect   = ~w_in_load & bus.redirect_valid;
    assign w_fetch_addr = r_pc[ADDR_W-1:0] + ADDR_W'(r_k);

    assign bus.mem_addr    = w_in_load ? r_ptr : w_fetch_addr;
    assign bus.mem_we      = w_accept;
    assign bus.mem_wdata   = bus.load_data;
    assign bus.load_ready  = r_load_ready;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.pc          = r_pc;
    assign bus.misalign    = r_misalign;

    // Sequencer: load phase, four-beat fetch, hold until decode takes the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_LOAD;
            r_k           <= 3'd0;
            r_ptr         <= {ADDR_W{1'b0}};
            r_pc          <= RESET_PC;
            r_load_ready  <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0000_0000;
            r_instr_pc    <= 32'h0000_0000;
            r_misalign    <= 1'b0;
            r_lanes       <= 24'h00_0000;
        end else begin
            r_misalign <= 1'b0;
            if (w_redirect) begin
                // Redirect beats stall and acceptance; any partial word is dropped.
                r_pc          <= {bus.redirect_pc[31:2], 2'b00};
                r_instr_valid <= 1'b0;
                r_k           <= 3'd0;
                r_state       <= ST_FETCH;
                r_misalign    <= |bus.redirect_pc[1:0];
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_load_exit) begin
                            r_state      <= ST_FETCH;
                            r_k          <= 3'd0;
                            r_load_ready <= 1'b0;
                            r_pc         <= RESET_PC;
                        end else begin
                            r_load_ready <= 1'b1;
                            if (w_accept) begin
                                r_ptr <= r_ptr + ADDR_W'(1'b1);
                            end
                        end
                    end
                    ST_FETCH: begin
                        // Read data lags the address by one beat, so beat k lands lane 4-k.
                        case (r_k)
                            3'd1: r_lanes[23:16] <= bus.mem_rdata;
                            3'd2: r_lanes[15:8]  <= bus.mem_rdata;
                            3'd3: r_lanes[7:0]   <= bus.mem_rdata;
                            3'd4: begin
                                r_instr       <= {r_lanes, bus.mem_rdata};
                                r_instr_pc    <= r_pc;
                                r_instr_valid <= 1'b1;
                                r_state       <= ST_HOLD;
                            end
                            default: ;
                        endcase
                        r_k <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
                    end
                    ST_HOLD: begin
                        if (!bus.stall) begin
                            r_pc          <= r_pc + 32'd4;
                            r_instr_valid <= 1'b0;
                            r_k           <= 3'd0;
                            r_state       <= ST_FETCH;
                        end
                    end
                    default: begin
                        r_state       <= ST_LOAD;
                        r_load_ready  <= 1'b0;
                        r_instr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl: a transaction-level model (memory image,
// fetch timer, architectural pc) predicts every output each cycle.
module tb_imem_fetch_ctrl;
    localparam int          AW   = 9;
    localparam int          SIZE = 1 << AW;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    imem_fetch_if #(.ADDR_W(AW)) bus ();

    imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous-read byte memory on the controller's port.
    logic [7:0] tb_mem [SIZE];
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    int mis_count = 0;
    bit last_we = 1'b0;

    // Reference model state
    logic [7:0]    img [SIZE];
    bit            m_init = 1'b0;
    bit            m_loading, m_ready, m_valid, m_mis;
    logic [AW-1:0] m_ptr;
    logic [31:0]   m_pc, m_instr, m_ipc;
    int            m_cnt;

    logic [7:0] prog [$] = '{8'h00, 8'h43, 8'h08, 8'h20, 8'h00, 8'h43, 8'h08, 8'h22,
                             8'h00, 8'h62, 8'h08, 8'h20};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = {w[23:0], img[AW'(a + 32'(i))]};
        return w;
    endfunction

    task automatic model_step();
        bit acc;
        if (rst) begin
            m_init = 1'b1; m_loading = 1'b1; m_ready = 1'b0; m_ptr = '0; m_pc = RPC;
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_mis = 1'b0; m_cnt = 0;
        end else if (m_loading) begin
            m_mis = 1'b0;
            acc = bus.load_valid && m_ready;
            if (acc) img[m_ptr] = bus.load_data;
            if (bus.load_done || (acc && m_ptr == AW'(SIZE - 1))) begin
                m_loading = 1'b0; m_ready = 1'b0; m_pc = RPC; m_cnt = 0;
            end else begin
                m_ready = 1'b1;
                if (acc) m_ptr = m_ptr + 1'b1;
            end
        end else begin
            m_mis = 1'b0;
            if (bus.redirect_valid) begin
                m_pc = {bus.redirect_pc[31:2], 2'b00}; m_valid = 1'b0; m_cnt = 0;
                m_mis = (bus.redirect_pc[1:0] != 2'b00);
            end else if (m_valid) begin
                if (!bus.stall) begin m_pc = m_pc + 32'd4; m_valid = 1'b0; m_cnt = 0; end
            end else if (m_cnt == 4) begin
                m_valid = 1'b1; m_instr = word_at(m_pc); m_ipc = m_pc;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One clock: check write port mid-cycle, advance model at the edge, check registers after.
    task automatic tick();
        bit exp_we;
        @(negedge clk);
        exp_we = !rst && m_loading && m_ready && bus.load_valid;
        last_we = bus.mem_we;
        if (bus.mem_we) we_count++;
        if (m_init) begin
            check_eq("mem_we", bus.mem_we, exp_we);
            if (exp_we) begin
                check_eq("mem_addr", bus.mem_addr, m_ptr);
                check_eq("mem_wdata", bus.mem_wdata, bus.load_data);
            end
        end
        @(posedge clk);
        model_step();
        #1;
        if (bus.misalign) mis_count++;
        if (m_init) begin
            check_eq("load_ready", bus.load_ready, m_ready);
            check_eq("instr_valid", bus.instr_valid, m_valid);
            check_eq("instr", bus.instr, m_instr);
            check_eq("instr_pc", bus.instr_pc, m_ipc);
            check_eq("pc", bus.pc, m_pc);
            check_eq("misalign", bus.misalign, m_mis);
        end
    endtask

    task automatic idle_inputs();
        bus.load_valid = 1'b0; bus.load_data = 8'h00; bus.load_done = 1'b0;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic load_seq(input logic [7:0] b [$], input bit done_last, input int gap_pct);
        for (int i = 0; i < b.size(); i++) begin
            int tries = 0;
            last_we = 1'b0;
            while (!last_we && tries < 20) begin
                bus.load_valid = ($urandom_range(0, 99) >= gap_pct);
                bus.load_data  = bus.load_valid ? b[i] : 8'($urandom);
                bus.load_done  = done_last && (i == b.size() - 1) && bus.load_valid;
                tick();
                tries++;
            end
            check_eq("load_accept", last_we, 1'b1);
        end
        bus.load_valid = 1'b0; bus.load_done = 1'b0;
    endtask

    task automatic run_until_valid(input string tag, input logic [31:0] exp_pc,
                                   input logic [31:0] exp_instr, input int max, output int n);
        bit seen = 1'b0;
        bit prev;
        n = 0;
        while (!seen && n < max) begin
            prev = bus.instr_valid;
            tick();
            n++;
            if (bus.instr_valid && !prev) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, seen, 1'b1);
        check_eq({tag, "_pc"}, bus.instr_pc, exp_pc);
        check_eq({tag, "_instr"}, bus.instr, exp_instr);
    endtask

    task automatic random_run(input int cycles, input bit allow_rst);
        for (int c = 0; c < cycles; c++) begin
            rst = allow_rst && ($urandom_range(0, 79) == 0);
            bus.load_valid = !rst && ($urandom_range(0, 1) == 1);
            bus.load_data = 8'($urandom);
            bus.load_done = ($urandom_range(0, 29) == 0);
            bus.stall = ($urandom_range(0, 2) == 0);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: bus.redirect_pc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                1: bus.redirect_pc = $urandom;
                default: bus.redirect_pc = 32'($urandom_range(0, 63));
            endcase
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        logic [7:0] full [$];
        logic [7:0] b5 [$];
        int n;
        idle_inputs();
        rst = 1'b1;

        // Full memory load with no load_done: auto exit after the last address.
        do_reset(2);
        for (int i = 0; i < SIZE; i++) full.push_back(8'($urandom));
        load_seq(full, 1'b0, 25);
        check_eq("full_load_ready", bus.load_ready, 1'b0);
        bus.load_valid = 1'b1; bus.load_data = 8'hA5;
        tick();
        bus.load_valid = 1'b0;
        random_run(300, 1'b0);

        // Program load and three unstalled words.
        do_reset(1);
        we_count = 0;
        load_seq(prog, 1'b0, 0);
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        run_until_valid("w0", 32'h0, 32'h0043_0820, 20, n);
        check_eq("w0_latency", n, 5);
        run_until_valid("w1", 32'h4, 32'h0043_0822, 20, n);
        check_eq("w1_latency", n, 6);
        run_until_valid("w2", 32'h8, 32'h0062_0820, 20, n);
        check_eq("w2_latency", n, 6);
        check_eq("we_count", we_count, 12);

        // Stall holds the word at pc 0 for three cycles.
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        run_until_valid("stall_w", 32'h0, 32'h0043_0820, 20, n);
        repeat (2) begin
            tick();
            check_eq("stall_instr", bus.instr, 32'h0043_0820);
            check_eq("stall_pc", bus.pc, 32'h0);
        end
        bus.stall = 1'b0;
        tick();
        check_eq("unstall_pc", bus.pc, 32'h4);

        // Redirect to 8 during beat k=2 of the word at 4, then misaligned redirect to 6.
        n = 0;
        while (!(!m_loading && !m_valid && m_cnt == 2) && n < 20) begin tick(); n++; end
        mis_count = 0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8;
        tick();
        bus.redirect_valid = 1'b0;
        run_until_valid("redir8", 32'h8, 32'h0062_0820, 20, n);
        check_eq("redir8_mis", mis_count, 0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
        tick();
        bus.redirect_valid = 1'b0;
        check_eq("redir6_pc", bus.pc, 32'h4);
        run_until_valid("redir6", 32'h4, 32'h0043_0822, 20, n);
        check_eq("redir6_mis", mis_count, 1);

        // load_done together with a byte: that byte is still written.
        do_reset(1);
        we_count = 0;
        for (int i = 0; i < 5; i++) b5.push_back(8'($urandom));
        load_seq(b5, 1'b1, 0);
        check_eq("done_we_count", we_count, 5);
        run_until_valid("dl0", 32'h0, {b5[0], b5[1], b5[2], b5[3]}, 20, n);
        run_until_valid("dl1", 32'h4, {b5[4], 8'h43, 8'h08, 8'h22}, 20, n);

        // Reset at beat k=3, then reload.
        n = 0;
        while (!(!m_loading && !m_valid && m_cnt == 3) && n < 20) begin tick(); n++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_valid", bus.instr_valid, 1'b0);
        check_eq("rst_pc", bus.pc, RPC);
        check_eq("rst_ready", bus.load_ready, 1'b0);
        tick();
        check_eq("post_rst_ready", bus.load_ready, 1'b1);
        load_seq(prog, 1'b0, 0);
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        run_until_valid("reload", 32'h0, 32'h0043_0820, 20, n);

        random_run(2500, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
